regfile_param: RTL and testbench

Parametrised MIPS general-purpose register file: the next generation of the single-clock 32×32 register file in the CPU datapath. It sits between decode and execute. It adds:
- asynchronous reset;
- a hardware scrub that zeroes every register after reset;
- write-to-read bypass;
- a registered jump-register target capture;
- parametrised tap registers for the syscall logic.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_scrub_ctrl.sv | 60 ++++++
 rtl/regfile_param.sv | 130 +++++++++++++
 tb/tb_regfile_param.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the MIPS register file: ABI register indices
// and the scrub/run state encoding used by the scrub controller.
package regfile_pkg;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_AT   = 1;
  localparam int unsigned REG_V0   = 2;
  localparam int unsigned REG_A0   = 4;
  localparam int unsigned REG_SP   = 29;
  localparam int unsigned REG_FP   = 30;
  localparam int unsigned REG_RA   = 31;

  typedef enum logic {
    SCRUB = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_scrub_ctrl.sv
// Post-reset scrub sequencer: walks every register index once, then
// raises ready.
// Ports: clk, rst (async, high) in; scrub_we, scrub_addr, ready out.
module regfile_scrub_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  output logic              scrub_we,
  output logic [ADDR_W-1:0] scrub_addr,
  output logic              ready
);

  // One extra bit so the terminal count DEPTH never wraps to 0.
  localparam logic [ADDR_W:0] LAST =
    {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] ONE =
    {{ADDR_W{1'b0}}, 1'b1};

  rf_state_e       state_q, state_d;
  logic [ADDR_W:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SCRUB;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      SCRUB: begin
        cnt_d = cnt_q + ONE;
        if (cnt_q == LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = SCRUB;
      end
    endcase
  end

  always_comb begin
    scrub_we   = (state_q == SCRUB);
    scrub_addr = cnt_q[ADDR_W-1:0];
    ready      = (state_q == RUN);
  end

endmodule

// File: rtl/regfile_param.sv
// Parametrised MIPS GPR file with scrub, write bypass, jr capture, taps.
// Ports: clk, rst, read/write indices and data, reg_write, jump_reg in;
// read_data_1/2, jr_target, sys_call_reg, std_out_address, ready out.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned BYPASS      = 1,
  parameter int unsigned SYSCALL_IDX = REG_V0,
  parameter int unsigned STDOUT_IDX  = REG_A0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_reg_1,
  input  logic [ADDR_W-1:0] read_reg_2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              reg_write,
  input  logic              jump_reg,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  output logic [DATA_W-1:0] jr_target,
  output logic [DATA_W-1:0] sys_call_reg,
  output logic [DATA_W-1:0] std_out_address,
  output logic              ready
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] SYS_A =
    ADDR_W'(SYSCALL_IDX);
  localparam logic [ADDR_W-1:0] OUT_A =
    ADDR_W'(STDOUT_IDX);
  localparam bit BYP = (BYPASS != 0);

  logic              scrub_we;
  logic [ADDR_W-1:0] scrub_addr;
  logic              rdy;

  regfile_scrub_ctrl #(
    .ADDR_W(ADDR_W)
  ) u_scrub (
    .clk       (clk),
    .rst       (rst),
    .scrub_we  (scrub_we),
    .scrub_addr(scrub_addr),
    .ready     (rdy)
  );

  // Array carries no reset; the scrub pass clears it instead.
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              usr_we;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  always_comb begin
    usr_we  = rdy & reg_write
            & (write_reg != '0);
    wr_en   = scrub_we | usr_we;
    wr_addr = scrub_we ? scrub_addr : write_reg;
    wr_data = scrub_we ? '0 : write_data;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  logic hit1, hit2;

  always_comb begin
    hit1 = BYP && reg_write
         && (write_reg == read_reg_1);
    hit2 = BYP && reg_write
         && (write_reg == read_reg_2);
  end

  // Index 0 short-circuits before the bypass check, so a
  // discarded write to $zero is never forwarded.
  always_comb begin
    read_data_1 = '0;
    if (rdy && (read_reg_1 != '0)) begin
      read_data_1 = hit1 ? write_data
                         : mem_q[read_reg_1];
    end
  end

  always_comb begin
    read_data_2 = '0;
    if (rdy && (read_reg_2 != '0)) begin
      read_data_2 = hit2 ? write_data
                         : mem_q[read_reg_2];
    end
  end

  always_comb begin
    sys_call_reg    = '0;
    std_out_address = '0;
    if (rdy) begin
      sys_call_reg    = (SYS_A == '0) ? '0
                                      : mem_q[SYS_A];
      std_out_address = (OUT_A == '0) ? '0
                                      : mem_q[OUT_A];
    end
  end

  logic [DATA_W-1:0] jr_q, jr_d;

  always_comb begin
    jr_d = jr_q;
    if (rdy && jump_reg) begin
      jr_d = read_data_1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      jr_q <= '0;
    end else begin
      jr_q <= jr_d;
    end
  end

  assign jr_target = jr_q;
  assign ready     = rdy;

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: bypassed (dut) and unbypassed
// (dut0) instances share every input.
module tb_regfile_param;

  logic        clk;
  logic        rst;
  logic [4:0]  read_reg_1, read_reg_2, write_reg;
  logic [31:0] write_data;
  logic        reg_write, jump_reg;

  logic [31:0] rd1, rd2, jr, sys, sout;
  logic        rdy;
  logic [31:0] b_rd1, b_rd2, b_jr, b_sys, b_sout;
  logic        b_rdy;

  int total = 0;
  int bad   = 0;
  int cnt;

  regfile_param dut (
    .clk            (clk),
    .rst            (rst),
    .read_reg_1     (read_reg_1),
    .read_reg_2     (read_reg_2),
    .write_reg      (write_reg),
    .write_data     (write_data),
    .reg_write      (reg_write),
    .jump_reg       (jump_reg),
    .read_data_1    (rd1),
    .read_data_2    (rd2),
    .jr_target      (jr),
    .sys_call_reg   (sys),
    .std_out_address(sout),
    .ready          (rdy)
  );

  regfile_param #(
    .BYPASS(0)
  ) dut0 (
    .clk            (clk),
    .rst            (rst),
    .read_reg_1     (read_reg_1),
    .read_reg_2     (read_reg_2),
    .write_reg      (write_reg),
    .write_data     (write_data),
    .reg_write      (reg_write),
    .jump_reg       (jump_reg),
    .read_data_1    (b_rd1),
    .read_data_2    (b_rd2),
    .jr_target      (b_jr),
    .sys_call_reg   (b_sys),
    .std_out_address(b_sout),
    .ready          (b_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    read_reg_1 = '0;
    read_reg_2 = '0;
    write_reg  = '0;
    write_data = '0;
    reg_write  = 1'b0;
    jump_reg   = 1'b0;
    #3;
    chk("rst_ready", {31'd0, rdy}, 32'd0);
    chk("rst_jr", jr, 32'd0);
    chk("rst_rd1", rd1, 32'd0);
    chk("rst_sys", sys, 32'd0);

    edge1();
    rst = 1'b0;
    cnt = 0;
    for (int i = 1; i <= 31; i++) begin
      edge1();
      if (rdy || b_rdy) cnt++;
    end
    chk("scrub_early", cnt, 32'd0);
    edge1();
    chk("ready_32", {31'd0, rdy}, 32'd1);
    chk("ready0_32", {31'd0, b_rdy}, 32'd1);

    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      read_reg_1 = 5'(i);
      read_reg_2 = 5'(31 - i);
      #1;
      if (rd1 != 0 || rd2 != 0) cnt++;
      if (b_rd1 != 0 || b_rd2 != 0) cnt++;
    end
    chk("scrub_zero", cnt, 32'd0);
    chk("tap_sys0", sys, 32'd0);
    chk("tap_out0", sout, 32'd0);

    write_reg  = 5'd5;
    write_data = 32'hDEADBEEF;
    reg_write  = 1'b1;
    read_reg_1 = 5'd5;
    read_reg_2 = 5'd5;
    #1;
    chk("byp_rd1", rd1, 32'hDEADBEEF);
    chk("byp_rd2", rd2, 32'hDEADBEEF);
    chk("nobyp_rd1", b_rd1, 32'd0);
    edge1();
    reg_write = 1'b0;
    #1;
    chk("byp_next", rd1, 32'hDEADBEEF);
    chk("nobyp_next", b_rd1, 32'hDEADBEEF);

    write_reg  = 5'd0;
    write_data = 32'h12345678;
    reg_write  = 1'b1;
    read_reg_1 = 5'd0;
    read_reg_2 = 5'd0;
    #1;
    chk("z_byp", rd1, 32'd0);
    edge1();
    reg_write = 1'b0;
    #1;
    chk("z_rd1", rd1, 32'd0);
    chk("z_rd2", rd2, 32'd0);
    chk("z0_rd1", b_rd1, 32'd0);

    write_reg  = 5'd2;
    write_data = 32'h0000000A;
    reg_write  = 1'b1;
    #1;
    chk("tap_sys_pre", sys, 32'd0);
    edge1();
    write_reg  = 5'd4;
    write_data = 32'h10010000;
    #1;
    chk("tap_sys", sys, 32'h0000000A);
    chk("tap_out_pre", sout, 32'd0);
    edge1();
    reg_write = 1'b0;
    #1;
    chk("tap_out", sout, 32'h10010000);
    chk("tap0_out", b_sout, 32'h10010000);

    write_reg  = 5'd31;
    write_data = 32'h00400020;
    reg_write  = 1'b1;
    edge1();
    reg_write  = 1'b0;
    read_reg_1 = 5'd31;
    jump_reg   = 1'b1;
    #1;
    chk("jr_pre", jr, 32'd0);
    edge1();
    jump_reg = 1'b0;
    #1;
    chk("jr_cap", jr, 32'h00400020);
    chk("jr0_cap", b_jr, 32'h00400020);
    write_data = 32'h11111111;
    reg_write  = 1'b1;
    edge1();
    reg_write = 1'b0;
    #1;
    chk("jr_hold", jr, 32'h00400020);
    chk("r31_new", rd1, 32'h11111111);

    // Capture takes the bypassed value on the bypass instance only.
    write_reg  = 5'd31;
    write_data = 32'h22222222;
    reg_write  = 1'b1;
    jump_reg   = 1'b1;
    edge1();
    reg_write = 1'b0;
    jump_reg  = 1'b0;
    #1;
    chk("jr_byp", jr, 32'h22222222);
    chk("jr_nobyp", b_jr, 32'h11111111);

    rst = 1'b1;
    #1;
    chk("rrst_ready", {31'd0, rdy}, 32'd0);
    chk("rrst_jr", jr, 32'd0);
    chk("rrst_sout", sout, 32'd0);
    edge1();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) edge1();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    write_reg  = 5'd7;
    write_data = 32'h00000055;
    reg_write  = 1'b1;
    read_reg_1 = 5'd7;
    jump_reg   = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 31; i++) begin
      edge1();
      if (rdy || b_rdy) cnt++;
      if (rd1 != 0) cnt++;
    end
    chk("rescrub_early", cnt, 32'd0);
    edge1();
    chk("rescrub_rdy", {31'd0, rdy}, 32'd1);
    reg_write = 1'b0;
    jump_reg  = 1'b0;
    #1;
    chk("ign_wr", rd1, 32'd0);
    chk("ign_jr", jr, 32'd0);
    read_reg_1 = 5'd5;
    read_reg_2 = 5'd31;
    #1;
    chk("lost_r5", rd1, 32'd0);
    chk("lost_r31", b_rd2, 32'd0);
    chk("lost_sout", sout, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
